// File: rtl/audio_soft_mute_pkg.sv
// audio_soft_mute_pkg: shared sample record and gain helpers for the soft-mute path
package audio_soft_mute_pkg;
  localparam int SAMPLE_W = 24;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } sample_t;
  function automatic int gain_unity(input int gw);
    return 1 << gw;
  endfunction
endpackage

// File: rtl/audio_soft_mute_if.sv
// audio_soft_mute_if: stereo Avalon-ST beat with valid/ready handshake
interface audio_soft_mute_if #(parameter int DATA_W = 24);
  logic signed [DATA_W-1:0] left;
  logic signed [DATA_W-1:0] right;
  logic valid;
  logic ready;
  modport master (output left, right, valid, input ready);
  modport slave (input left, right, valid, output ready);
endinterface

// File: rtl/audio_soft_mute_ramp.sv
// audio_soft_mute_ramp: mute synchronizer, saturating gain ramp and status flags
module audio_soft_mute_ramp
  import audio_soft_mute_pkg::*;
#(
  parameter int GAIN_W = 8,
  parameter int STEP = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic mute,
  input  logic adv,
  output logic [GAIN_W:0] gain,
  output logic muted,
  output logic ramping
);
  localparam logic [GAIN_W+1:0] UNITY = (GAIN_W+2)'(gain_unity(GAIN_W));
  localparam logic [GAIN_W+1:0] STP = (GAIN_W+2)'(STEP);
  logic m1_q, ms_q, muted_q, muted_d, ramping_q, ramping_d;
  logic [GAIN_W:0] gain_q, gain_d;
  logic [GAIN_W+1:0] g, dn, up;
  // Flags are registered from next state so ramping can reset low while gain is 0
  always_comb begin
    g = {1'b0, gain_q};
    dn = g > STP ? g - STP : '0;
    up = g + STP < UNITY ? g + STP : UNITY;
    gain_d = adv ? (ms_q ? (GAIN_W+1)'(dn) : (GAIN_W+1)'(up)) : gain_q;
    muted_d = gain_d == '0;
    ramping_d = m1_q ? gain_d != '0 : {1'b0, gain_d} != UNITY;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_q <= 1'b0;
      ms_q <= 1'b0;
      gain_q <= '0;
      muted_q <= 1'b1;
      ramping_q <= 1'b0;
    end else begin
      m1_q <= mute;
      ms_q <= m1_q;
      gain_q <= gain_d;
      muted_q <= muted_d;
      ramping_q <= ramping_d;
    end
  end
  assign gain = gain_q;
  assign muted = muted_q;
  assign ramping = ramping_q;
endmodule

// File: rtl/audio_soft_mute.sv
// audio_soft_mute: click-free stereo mute with a linear gain ramp and one output register
module audio_soft_mute
  import audio_soft_mute_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int GAIN_W = 8,
  parameter int STEP = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic mute,
  audio_soft_mute_if.slave in_s,
  audio_soft_mute_if.master out_m,
  output logic muted,
  output logic ramping
);
  localparam int PW = DATA_W + GAIN_W + 2;
  logic [GAIN_W:0] gain;
  logic acc, valid_q, valid_d;
  logic signed [DATA_W-1:0] left_q, left_d, right_q, right_d;
  logic signed [PW-1:0] gx, pl, pr;
  audio_soft_mute_ramp #(.GAIN_W(GAIN_W), .STEP(STEP)) u_ramp (
    .clk, .reset, .mute, .adv(acc), .gain, .muted, .ramping
  );
  assign in_s.ready = ~valid_q | out_m.ready;
  always_comb begin
    acc = in_s.valid & in_s.ready;
    gx = $signed({{(DATA_W+1){1'b0}}, gain});
    pl = $signed({{(GAIN_W+2){in_s.left[DATA_W-1]}}, in_s.left}) * gx;
    pr = $signed({{(GAIN_W+2){in_s.right[DATA_W-1]}}, in_s.right}) * gx;
    left_d = acc ? DATA_W'(pl >>> GAIN_W) : left_q;
    right_d = acc ? DATA_W'(pr >>> GAIN_W) : right_q;
    valid_d = acc | (valid_q & ~out_m.ready);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      left_q <= '0;
      right_q <= '0;
    end else begin
      valid_q <= valid_d;
      left_q <= left_d;
      right_q <= right_d;
    end
  end
  assign out_m.valid = valid_q;
  assign out_m.left = left_q;
  assign out_m.right = right_q;
endmodule

// File: tb/tb_audio_soft_mute.sv
// tb_audio_soft_mute: directed stimulus checked cycle-by-cycle against a behavioural gain model
module tb_audio_soft_mute;
  import audio_soft_mute_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mute = 1'b0;
  logic muted, ramping;
  int tests = 0;
  int fails = 0;
  audio_soft_mute_if #(.DATA_W(SAMPLE_W)) si();
  audio_soft_mute_if #(.DATA_W(SAMPLE_W)) so();
  audio_soft_mute dut (.clk(clk), .reset(reset), .mute(mute), .in_s(si), .out_m(so),
                       .muted(muted), .ramping(ramping));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [SAMPLE_W-1:0] a, input logic [SAMPLE_W-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", n, $time, a, e);
    end
  endtask

  // Model: gain is an integer in 0..256, mute seen two edges late, one output slot
  longint mg;
  logic m1, ms, mv, fresh;
  sample_t mo;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mg = 0; m1 = 0; ms = 0; mv = 0; mo = '0; fresh = 1;
    end else begin
      if (si.valid && (!mv || so.ready)) begin
        mo.left = SAMPLE_W'((longint'(si.left) * mg) >>> 8);
        mo.right = SAMPLE_W'((longint'(si.right) * mg) >>> 8);
        mv = 1;
        if (ms) mg = (mg == 0) ? 0 : mg - 1;
        else mg = (mg == 256) ? 256 : mg + 1;
      end else if (so.ready) mv = 0;
      ms = m1;
      m1 = mute;
      fresh = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", so.valid, mv);
    chk("in_ready", si.ready, !mv || so.ready);
    chk("out_left", so.left, mo.left);
    chk("out_right", so.right, mo.right);
    chk("muted", muted, mg == 0);
    chk("ramping", ramping, fresh ? 1'b0 : (ms ? mg != 0 : mg != 256));
  end

  task automatic step(input logic v, input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
    si.valid = v;
    si.left = l;
    si.right = r;
    @(negedge clk);
  endtask

  initial begin
    int rv[5];
    int e;
    rv = '{100, 99, 98, 99, 100};
    si.valid = 0; si.left = 0; si.right = 0; so.ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", so.valid, 0);
    chk("rst_muted", muted, 1);
    chk("rst_ramping", ramping, 0);
    chk("rst_left", so.left, 0);
    reset = 0;
    for (int k = 0; k < 260; k++) begin
      step(1, 24'h100000, 24'h100000);
      if (k inside {0, 1, 2, 128, 255, 256, 259}) chk("up_out", so.left, (k > 256 ? 256 : k) * 4096);
      if (k == 0) chk("up_muted0", muted, 0);
      if (k == 254) chk("up_ramp254", ramping, 1);
      if (k == 255) chk("up_ramp255", ramping, 0);
    end
    mute = 1;
    for (int j = 0; j < 263; j++) begin
      step(1, 24'h100000, 24'h100000);
      e = 258 - j;
      e = e > 256 ? 256 : (e < 0 ? 0 : e);
      if (j inside {0, 2, 3, 100, 257, 258, 262}) chk("dn_out", so.right, e * 4096);
    end
    chk("dn_muted", muted, 1);
    chk("dn_ramping", ramping, 0);
    mute = 0;
    step(1, 24'h800000, 24'h800000);
    chk("g0_left", so.left, 0);
    chk("g0_right", so.right, 0);
    for (int j = 1; j < 130; j++) step(1, 24'h100000, 24'h100000);
    chk("g127_left", so.left, 24'h07F000);
    step(1, 24'hFFFFFF, 24'h800000);
    chk("neg1_left", so.left, 24'hFFFFFF);
    chk("min_right", so.right, 24'hC00000);
    step(0, 0, 0);
    chk("idle_valid", so.valid, 0);
    so.ready = 0;
    step(1, 24'h100000, 24'h100000);
    chk("bp_first", so.left, 24'h081000);
    chk("bp_ready0", si.ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 24'h200000, 24'h200000);
      chk("bp_hold", so.left, 24'h081000);
      chk("bp_valid", so.valid, 1);
    end
    so.ready = 1;
    step(1, 24'h200000, 24'h200000);
    chk("bp_release", so.left, 24'h104000);
    step(1, 24'h100000, 24'h100000);
    chk("bp_next", so.left, 24'h083000);
    mute = 1;
    repeat (36) step(1, 24'h100000, 24'h100000);
    chk("rev_g101", so.left, 24'h065000);
    mute = 0;
    for (int k = 0; k < 5; k++) begin
      step(1, 24'h100000, 24'h100000);
      chk("rev_seq", so.left, rv[k] * 4096);
    end
    repeat (3) step(0, 0, 0);
    chk("rev_idle_valid", so.valid, 0);
    chk("rev_idle_hold", so.left, 100 * 4096);
    step(1, 24'h100000, 24'h100000);
    chk("rev_after_idle", so.left, 101 * 4096);
    repeat (5) step(1, 24'h100000, 24'h100000);
    chk("pre_rst_valid", so.valid, 1);
    #2 reset = 1;
    #1;
    chk("arst_valid", so.valid, 0);
    chk("arst_left", so.left, 0);
    chk("arst_muted", muted, 1);
    chk("arst_ramping", ramping, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      step(1, 24'h100000, 24'h100000);
      chk("restart_out", so.left, k * 4096);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/audio_soft_mute.md
Name: audio_soft_mute

Overview:
Consumes the 1-bit mute control from the audio_mute PIO and applies it click-free to the stereo sample stream heading to the audio codec. The gain ramps linearly between 0 and unity, stepping once per accepted sample pair, instead of cutting the signal instantly. It sits inline on the Avalon-ST audio path between the sample source and the codec interface.

Parameters:
DATA_W, 24, signed sample width per channel.
GAIN_W, 8, gain fraction bits; unity gain = 2**GAIN_W; gain register is GAIN_W+1 bits.
STEP, 1, gain increment/decrement per accepted beat (1..2**GAIN_W).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mute  in  1  mute request (level) from PIO out_port; may be asynchronous to clk
in_left  in  DATA_W  left sample, two's complement
in_right  in  DATA_W  right sample, two's complement
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
out_left  out  DATA_W  scaled left sample
out_right  out  DATA_W  scaled right sample
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
muted  out  1  high when gain == 0
ramping  out  1  high when gain is not at the target set by mute_s

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: gain=0, mute sync flops=0, out_valid=0, out_left=out_right=0, muted=1, ramping=0. A module leaving reset with mute=0 therefore ramps up from silence. This is intentional and gives a click-free power-up.
- mute passes through a 2-flop synchronizer to give mute_s. There are 2 cycles of latency before mute_s affects the ramp.
- Handshake: single output register. in_ready = ~out_valid | out_ready (combinational).
  - On an accepted beat, out_* load the scaled samples and out_valid goes to 1 on the next edge. Latency is 1 cycle.
  - If out_ready & out_valid and there is no accepted input, out_valid goes to 0.
  - While out_valid & ~out_ready, out_* are held stable.
- Scaling: out = (in * gain) >>> GAIN_W, using a signed multiply and an arithmetic shift (floor rounding).
  - The product is DATA_W+GAIN_W+1 bits signed.
  - gain = unity gives out == in exactly. gain = 0 gives out = 0.
  - No overflow is possible because gain <= unity.
- Gain update: happens only on accepted beats, never on idle cycles. Each beat is scaled by the gain value current at acceptance; gain updates on the same edge.
  - mute_s=1: gain <= (gain > STEP) ? gain-STEP : 0.
  - mute_s=0: gain <= (gain + STEP < unity) ? gain+STEP : unity.
  - Saturates at both ends; never wraps.
- muted and ramping are derived from registered state. ramping = (mute_s & gain != 0) | (~mute_s & gain != unity).
- A mute toggle mid-ramp reverses direction from the current gain. The gain never jumps.
- Reset mid-operation: everything returns to the reset values immediately; any in-flight output beat is dropped.
- Both channels always use the identical gain value.

Decomposition:
- Package audio_soft_mute_pkg: GAIN_UNITY function/constant of GAIN_W, and the sample record typedef {left, right}.
- One sub-module, audio_soft_mute_ramp. It contains the mute synchronizer, the saturating gain register (advance strobe = accepted beat), and the muted/ramping flags.
- Multiply, shift and output register stay in the top level.

Test Plan:
All scenarios use defaults (DATA_W=24, GAIN_W=8, STEP=1).
1. Reset release, mute=0, continuous beats of 0x100000, out_ready=1 -> outputs 0, 0x001000, 0x002000, ... (4096*k); beat 256 onward = 0x100000; ramping falls at gain=256, muted deasserts after beat 0.
2. At unity, assert mute -> after 2-cycle sync, outputs step down by 0x001000 per beat; reach 0 after 256 beats; muted=1, ramping=0; further beats output 0.
3. Sign handling: in=0xFFFFFF (-1) at gain 128 -> out 0xFFFFFF; in=0x800000 at gain 128 -> 0xC00000; at gain 0 -> 0x000000.
4. Backpressure: in_valid=1, out_ready=0 for 5 cycles -> in_ready=0 after first beat, out_* stable, gain unchanged. Release -> one beat per cycle resumes with no lost or duplicated beat.
5. Reversal: ramping down at gain 100, deassert mute -> gain sequence 100, 99, 98 (sync latency), then 99, 100, 101... No idle-cycle gain change when in_valid=0.
6. Assert reset mid-ramp with out_valid=1 -> out_valid=0, out_*=0, muted=1 asynchronously. After release, ramp restarts from 0.
